// File: rtl/instruction_sequencer_if.sv
// Control/status bundle between the instruction sequencer and the datapath it steers.
// The master side is the sequencer; the slave side supplies Run/Opcode and consumes controls.
interface instruction_sequencer_if;
  logic       Run;
  logic [3:0] Opcode;
  logic       EnablePC;
  logic       IncPC;
  logic       LoadMAR;
  logic       EnableRAM;
  logic       LatchInstrReg;
  logic       EnableInstrReg;
  logic       ClearInstrReg;
  logic       LoadAcc;
  logic       EnableAcc;
  logic       LoadB;
  logic       EnableALU;
  logic       Sub;
  logic       LoadOut;
  logic       Halted;
  logic [2:0] TState;

  modport master (
    input  Run, Opcode,
    output EnablePC, IncPC, LoadMAR, EnableRAM, LatchInstrReg, EnableInstrReg, ClearInstrReg,
           LoadAcc, EnableAcc, LoadB, EnableALU, Sub, LoadOut, Halted, TState
  );

  modport slave (
    output Run, Opcode,
    input  EnablePC, IncPC, LoadMAR, EnableRAM, LatchInstrReg, EnableInstrReg, ClearInstrReg,
           LoadAcc, EnableAcc, LoadB, EnableALU, Sub, LoadOut, Halted, TState
  );
endinterface

// File: rtl/instruction_sequencer.sv
// T-state sequencer for a small accumulator machine: fetch in T1-T3, execute LDA/ADD/SUB/OUT/HLT
// in T4-T6. Controls are decoded from the registered state and the live opcode only.
module instruction_sequencer (
  input logic MainClock,
  input logic Clear,
  instruction_sequencer_if.master bus
);

  typedef enum logic [2:0] {StIdle, StT1, StT2, StT3, StT4, StT5, StT6, StHalt} state_e;

  localparam logic [3:0] OpLda = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpOut = 4'b1110;
  localparam logic [3:0] OpHlt = 4'b1111;

  state_e state_q, state_d;
  state_e instr_end;
  logic   is_mem_op;
  logic   is_alu_op;

  assign is_mem_op = (bus.Opcode == OpLda) || (bus.Opcode == OpAdd) || (bus.Opcode == OpSub);
  assign is_alu_op = (bus.Opcode == OpAdd) || (bus.Opcode == OpSub);

  // Run is only consulted at fetch boundaries; an instruction past T1 always completes.
  assign instr_end = bus.Run ? StT1 : StIdle;

  always_ff @(posedge MainClock or posedge Clear) begin
    if (Clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: state_d = bus.Run ? StT1 : StIdle;
      StT1:   state_d = StT2;
      StT2:   state_d = StT3;
      StT3:   state_d = StT4;
      StT4: begin
        if (is_mem_op) begin
          state_d = StT5;
        end else if (bus.Opcode == OpHlt) begin
          state_d = StHalt;
        end else begin
          state_d = instr_end;
        end
      end
      StT5:   state_d = is_alu_op ? StT6 : instr_end;
      StT6:   state_d = instr_end;
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.EnablePC       = 1'b0;
    bus.IncPC          = 1'b0;
    bus.LoadMAR        = 1'b0;
    bus.EnableRAM      = 1'b0;
    bus.LatchInstrReg  = 1'b0;
    bus.EnableInstrReg = 1'b0;
    bus.LoadAcc        = 1'b0;
    bus.EnableAcc      = 1'b0;
    bus.LoadB          = 1'b0;
    bus.EnableALU      = 1'b0;
    bus.Sub            = 1'b0;
    bus.LoadOut        = 1'b0;
    bus.Halted         = 1'b0;
    bus.TState         = 3'd0;
    case (state_q)
      StT1: begin
        bus.TState   = 3'd1;
        bus.EnablePC = 1'b1;
        bus.LoadMAR  = 1'b1;
      end
      StT2: begin
        bus.TState = 3'd2;
        bus.IncPC  = 1'b1;
      end
      StT3: begin
        bus.TState        = 3'd3;
        bus.EnableRAM     = 1'b1;
        bus.LatchInstrReg = 1'b1;
      end
      StT4: begin
        bus.TState = 3'd4;
        if (is_mem_op) begin
          bus.EnableInstrReg = 1'b1;
          bus.LoadMAR        = 1'b1;
        end else if (bus.Opcode == OpOut) begin
          bus.EnableAcc = 1'b1;
          bus.LoadOut   = 1'b1;
        end
      end
      StT5: begin
        bus.TState = 3'd5;
        if (bus.Opcode == OpLda) begin
          bus.EnableRAM = 1'b1;
          bus.LoadAcc   = 1'b1;
        end else if (is_alu_op) begin
          bus.EnableRAM = 1'b1;
          bus.LoadB     = 1'b1;
        end
      end
      StT6: begin
        bus.TState = 3'd6;
        if (is_alu_op) begin
          bus.EnableALU = 1'b1;
          bus.LoadAcc   = 1'b1;
          bus.Sub       = (bus.Opcode == OpSub);
        end
      end
      StHalt: bus.Halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.ClearInstrReg = Clear;

endmodule
